multi_arbiter: RTL and testbench
================================

MULTI_ARBITER -- requirements
Module: multi_arbiter

Interface
REQ-001 SHALL have parameter NPORTS, default 2, number of requester ports (2..8); port 0 is the data port and port 1 the instruction port in the default core.
REQ-002 SHALL have parameter RR, default 1, arbitration mode: 0 = fixed priority (lowest index wins), 1 = round-robin.
REQ-003 SHALL have parameter TIMEOUT, default 1024, maximum number of cycles a memory access may stay in BUSY (only used with ARBITER_TIMEOUT_EN).
REQ-004 clk  input  1  clock; all state updates on its rising edge.
REQ-005 rst  input  1  reset, synchronous, active-low.
REQ-006 req_in  input  mem_in_type[NPORTS]  per-port request (mem_valid, mem_instr, mem_mode, mem_addr, mem_wdata, mem_wstrb).
REQ-007 req_out  output  mem_out_type[NPORTS]  per-port response (mem_ready, mem_error, mem_rdata).
REQ-008 pmp_in  output  pmp_in_type  granted request presented to the PMP checker.
REQ-009 pmp_out  input  pmp_out_type  combinational PMP verdict; mem_error=1 means access denied.
REQ-010 memory_valid, memory_instr  output  1 each  memory request strobe and instruction flag.
REQ-011 memory_addr, memory_wdata  output  32 each; memory_wstrb  output  4.
REQ-012 memory_rdata  input  32; memory_ready  input  1  memory completion.

Function
REQ-013 SHALL implement states IDLE, BUSY and ERR, plus a registered grant index g of width $clog2(NPORTS).
REQ-014 In IDLE, if any req_in[i].mem_valid=1, SHALL select one port i in the same cycle, latch its request fields, and set g=i.
REQ-015 RR=0: SHALL select the lowest valid index. RR=1: SHALL search from (last+1) mod NPORTS upward with wrap-around, and SHALL update last to i on each grant.
REQ-016 In the grant cycle, SHALL drive pmp_in from the selected request combinationally.
REQ-016a If pmp_out.mem_error=1, SHALL keep memory_valid=0 and go to ERR.
REQ-016b Otherwise SHALL drive memory_* with the selected request, memory_valid=1, in that same cycle, and go to BUSY.
REQ-017 In BUSY, SHALL drive memory_* from the latched request, held stable, and SHALL drive pmp_in from the latched request.
REQ-018 In BUSY, when memory_ready=1, SHALL set req_out[g].mem_ready=1, mem_error=0 and mem_rdata=memory_rdata in that same cycle, then go to IDLE.
REQ-019 New grants SHALL be issued only from IDLE, so there is one bubble cycle between accesses.
REQ-020 In ERR (one cycle), SHALL set req_out[g].mem_ready=1, mem_error=1 and mem_rdata=0, and memory_valid=0, then go to IDLE.
REQ-021 Non-granted ports, and every port whenever the state is IDLE, SHALL see mem_ready=0, mem_error=0 and mem_rdata=0.
REQ-022 A request that deasserts mem_valid while not granted SHALL be dropped without side effects; a granted request SHALL complete even if its mem_valid drops.
REQ-023 When memory is idle (IDLE with no request, or ERR), memory_addr, memory_wdata, memory_wstrb and memory_instr SHALL be 0.

Reset
REQ-024 When rst=0 at a clock edge: state SHALL be IDLE, g=0, last=NPORTS-1 (so port 0 wins first), and latched fields SHALL be 0.
REQ-025 Reset mid-access SHALL abandon the transaction; no req_out ready is issued for it, and all outputs SHALL be 0 in the following cycle.

Configuration
REQ-026 With ARBITER_TIMEOUT_EN defined: a cycle counter SHALL clear on entry to BUSY and increment each BUSY cycle without memory_ready.
REQ-026a If the counter reaches TIMEOUT-1 without memory_ready, SHALL deassert memory_valid on the next cycle and go to ERR.
REQ-026b A memory_ready arriving in the same cycle the counter reaches TIMEOUT-1 SHALL take precedence and complete normally.
REQ-027 Without ARBITER_TIMEOUT_EN: no counter SHALL exist, and BUSY SHALL wait indefinitely for memory_ready.

Verification
REQ-028 NPORTS=2, RR=1: ports 0 and 1 both valid continuously, memory_ready 1 cycle after each grant -> grants alternate 0,1,0,1.
REQ-029 RR=0, same stimulus -> port 0 is granted every time; port 1 is never granted while port 0 stays valid.
REQ-030 Port 1 request to addr 0x8000_0000 with pmp_out.mem_error=1 -> memory_valid stays 0; the next cycle req_out[1].mem_ready=1, mem_error=1, mem_rdata=0.
REQ-031 Port 0 load from addr 0x100; memory_ready=1 with rdata=0xDEADBEEF 3 cycles later -> req_out[0].mem_rdata=0xDEADBEEF with mem_ready=1 in that cycle, and memory_addr is held at 0x100 throughout.
REQ-032 ARBITER_TIMEOUT_EN defined, TIMEOUT=16, memory_ready never asserted -> memory_valid drops after 16 BUSY cycles and the granted port receives mem_error=1.
REQ-033 rst=0 during BUSY -> next cycle all outputs are 0; after release, with both ports valid, port 0 is granted first.

Source files
------------

// File: rtl/multi_arbiter.sv
// rtl/multi_arbiter.sv - N-port memory arbiter with PMP check and optional access timeout
//
// Purpose:
//   Arbitrates NPORTS requesters onto one memory port. A grant is issued only
//   from IDLE, either by fixed priority (RR=0) or round-robin (RR=1). The
//   granted request is checked by an external combinational PMP; a denied
//   access is answered with an error and never reaches memory.
//
// Optional feature macro:
//   ARBITER_TIMEOUT_EN - abort a BUSY access after TIMEOUT cycles without
//                        memory_ready and answer it with an error.
//
// Ports:
//   clk           clock, rising edge
//   rst           synchronous, active-low reset
//   req_in[i]     per-port request (valid, instr, mode, addr, wdata, wstrb)
//   req_out[i]    per-port response (ready, error, rdata)
//   pmp_in        request presented to the PMP checker
//   pmp_out       PMP verdict, mem_error=1 denies the access
//   memory_valid  memory request strobe
//   memory_instr  instruction fetch flag
//   memory_addr   memory address
//   memory_wdata  memory write data
//   memory_wstrb  memory byte write strobes
//   memory_rdata  memory read data
//   memory_ready  memory completion

package multi_arbiter_pkg;

  typedef struct packed {
    logic        mem_valid;
    logic        mem_instr;
    logic [1:0]  mem_mode;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
  } mem_in_type;

  typedef struct packed {
    logic        mem_ready;
    logic        mem_error;
    logic [31:0] mem_rdata;
  } mem_out_type;

  typedef mem_in_type pmp_in_type;

  typedef struct packed {
    logic mem_error;
  } pmp_out_type;

endpackage

module multi_arbiter
  import multi_arbiter_pkg::*;
#(
  parameter int NPORTS  = 2,
  parameter int RR      = 1,
  parameter int TIMEOUT = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  mem_in_type  req_in [NPORTS],
  output mem_out_type req_out [NPORTS],
  output pmp_in_type  pmp_in,
  input  pmp_out_type pmp_out,
  output logic        memory_valid,
  output logic        memory_instr,
  output logic [31:0] memory_addr,
  output logic [31:0] memory_wdata,
  output logic [3:0]  memory_wstrb,
  input  logic [31:0] memory_rdata,
  input  logic        memory_ready
);

  localparam int GW = (NPORTS > 1) ? $clog2(NPORTS) : 1;

  if (NPORTS < 2 || NPORTS > 8 || TIMEOUT < 2) begin : g_bad_params
    $error("multi_arbiter: NPORTS must be 2..8 and TIMEOUT at least 2");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    ERR  = 2'd2
  } state_t;

  state_t     state, state_nxt;
  logic [GW-1:0] g, g_nxt;
  logic [GW-1:0] last, last_nxt;
  mem_in_type lat, lat_nxt;

  logic          sel_found;
  logic [GW-1:0] sel_idx;
  logic [GW-1:0] cand_idx;
  int            cand;

`ifdef ARBITER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT) + 1;
  logic [TW-1:0] tmo_cnt;
  logic          tmo_hit;

  assign tmo_hit = (tmo_cnt == TW'(TIMEOUT - 1));

  // Counts BUSY cycles without memory_ready; zero whenever not in BUSY so it
  // starts from zero on every entry to BUSY.
  always_ff @(posedge clk) begin
    if (!rst || state != BUSY) begin
      tmo_cnt <= '0;
    end else if (!memory_ready) begin
      tmo_cnt <= tmo_cnt + TW'(1);
    end
  end
`endif

  // Request selection. Round-robin starts the search just after the last
  // granted port; fixed priority always starts at port 0. While reset is held
  // nothing is selected, so outputs stay quiet until reset is released.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    cand      = 0;
    cand_idx  = '0;
    if (rst) begin
      for (int k = 0; k < NPORTS; k++) begin
        if (RR != 0) begin
          cand = (int'(last) + 1 + k) % NPORTS;
        end else begin
          cand = k;
        end
        cand_idx = GW'(cand);
        if (!sel_found && req_in[cand_idx].mem_valid) begin
          sel_found = 1'b1;
          sel_idx   = cand_idx;
        end
      end
    end
  end

  always_comb begin
    state_nxt    = state;
    g_nxt        = g;
    last_nxt     = last;
    lat_nxt      = lat;
    pmp_in       = '0;
    memory_valid = 1'b0;
    memory_instr = 1'b0;
    memory_addr  = '0;
    memory_wdata = '0;
    memory_wstrb = '0;
    for (int k = 0; k < NPORTS; k++) begin
      req_out[k] = '0;
    end

    case (state)
      IDLE: begin
        if (sel_found) begin
          pmp_in   = req_in[sel_idx];
          g_nxt    = sel_idx;
          last_nxt = sel_idx;
          lat_nxt  = req_in[sel_idx];
          if (pmp_out.mem_error) begin
            state_nxt = ERR;
          end else begin
            // Memory sees the request in the grant cycle itself, straight
            // from the requester rather than from the latch.
            memory_valid = 1'b1;
            memory_instr = req_in[sel_idx].mem_instr;
            memory_addr  = req_in[sel_idx].mem_addr;
            memory_wdata = req_in[sel_idx].mem_wdata;
            memory_wstrb = req_in[sel_idx].mem_wstrb;
            state_nxt    = BUSY;
          end
        end
      end

      BUSY: begin
        pmp_in       = lat;
        memory_valid = 1'b1;
        memory_instr = lat.mem_instr;
        memory_addr  = lat.mem_addr;
        memory_wdata = lat.mem_wdata;
        memory_wstrb = lat.mem_wstrb;
        if (memory_ready) begin
          req_out[g].mem_ready = 1'b1;
          req_out[g].mem_rdata = memory_rdata;
          state_nxt            = IDLE;
        end
`ifdef ARBITER_TIMEOUT_EN
        else if (tmo_hit) begin
          state_nxt = ERR;
        end
`endif
      end

      ERR: begin
        req_out[g].mem_ready = 1'b1;
        req_out[g].mem_error = 1'b1;
        state_nxt            = IDLE;
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // last resets to the top port so that port 0 is the first round-robin winner.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      g     <= '0;
      last  <= GW'(NPORTS - 1);
      lat   <= '0;
    end else begin
      state <= state_nxt;
      g     <= g_nxt;
      last  <= last_nxt;
      lat   <= lat_nxt;
    end
  end

endmodule

// File: tb/tb_multi_arbiter.sv
// tb/tb_multi_arbiter.sv - directed testbench for multi_arbiter
module tb_multi_arbiter;
  import multi_arbiter_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  mem_in_type  req_in [2];
  mem_out_type req_out [2];
  mem_out_type fp_req_out [2];
  pmp_in_type  pmp_in, fp_pmp_in;
  pmp_out_type pmp_out;
  logic        memory_valid, memory_instr;
  logic [31:0] memory_addr, memory_wdata;
  logic [3:0]  memory_wstrb;
  logic        fp_memory_valid, fp_memory_instr;
  logic [31:0] fp_memory_addr, fp_memory_wdata;
  logic [3:0]  fp_memory_wstrb;
  logic [31:0] memory_rdata;
  logic        memory_ready;

  int tests_run    = 0;
  int tests_failed = 0;

  multi_arbiter #(.NPORTS(2), .RR(1), .TIMEOUT(16)) dut (
    .clk(clk), .rst(rst), .req_in(req_in), .req_out(req_out),
    .pmp_in(pmp_in), .pmp_out(pmp_out),
    .memory_valid(memory_valid), .memory_instr(memory_instr),
    .memory_addr(memory_addr), .memory_wdata(memory_wdata),
    .memory_wstrb(memory_wstrb), .memory_rdata(memory_rdata),
    .memory_ready(memory_ready)
  );

  multi_arbiter #(.NPORTS(2), .RR(0), .TIMEOUT(16)) dut_fp (
    .clk(clk), .rst(rst), .req_in(req_in), .req_out(fp_req_out),
    .pmp_in(fp_pmp_in), .pmp_out(pmp_out),
    .memory_valid(fp_memory_valid), .memory_instr(fp_memory_instr),
    .memory_addr(fp_memory_addr), .memory_wdata(fp_memory_wdata),
    .memory_wstrb(fp_memory_wstrb), .memory_rdata(memory_rdata),
    .memory_ready(memory_ready)
  );

  function automatic mem_in_type mk_req(input logic v, input logic i, input logic [31:0] a,
                                        input logic [31:0] d, input logic [3:0] s);
    mk_req           = '0;
    mk_req.mem_valid = v;
    mk_req.mem_instr = i;
    mk_req.mem_addr  = a;
    mk_req.mem_wdata = d;
    mk_req.mem_wstrb = s;
  endfunction

  task automatic next_cycle;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst          = 1'b0;
    req_in[0]    = '0;
    req_in[1]    = '0;
    pmp_out      = '0;
    memory_ready = 1'b0;
    memory_rdata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    tests_run++;
    if (memory_valid !== 1'b0 || memory_addr !== 32'h0 || fp_memory_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_memory: valid=%b addr=%h fp_valid=%b, want 0", memory_valid, memory_addr, fp_memory_valid);
    end
    tests_run++;
    if (pmp_in !== '0 || req_out[0] !== '0 || req_out[1] !== '0) begin
      tests_failed++;
      $display("FAIL reset_outputs: pmp_in=%h out0=%h out1=%h, want 0", pmp_in, req_out[0], req_out[1]);
    end
    @(posedge clk);
    #1 rst = 1'b1;
  endtask

  // Both ports valid continuously, memory always ready: round-robin alternates,
  // fixed priority keeps granting port 0.
  task automatic test_arbitration;
    logic [31:0] exp_addr;
    logic [31:0] exp_wdata;
    logic [3:0]  exp_wstrb;
    logic        exp_instr;
    mem_out_type got_win, got_lose;
    req_in[0]    = mk_req(1'b1, 1'b0, 32'h0000_1000, 32'h55AA_55AA, 4'hF);
    req_in[1]    = mk_req(1'b1, 1'b1, 32'h0000_2000, 32'h0, 4'h0);
    memory_ready = 1'b1;
    memory_rdata = 32'h1111_2222;
    for (int n = 0; n < 4; n++) begin
      exp_addr  = ((n % 2) == 0) ? 32'h0000_1000 : 32'h0000_2000;
      exp_wdata = ((n % 2) == 0) ? 32'h55AA_55AA : 32'h0;
      exp_wstrb = ((n % 2) == 0) ? 4'hF : 4'h0;
      exp_instr = ((n % 2) == 0) ? 1'b0 : 1'b1;
      @(negedge clk);
      tests_run++;
      if (memory_valid !== 1'b1 || memory_addr !== exp_addr || memory_instr !== exp_instr ||
          memory_wdata !== exp_wdata || memory_wstrb !== exp_wstrb) begin
        tests_failed++;
        $display("FAIL rr_grant%0d: valid=%b addr=%h instr=%b wdata=%h wstrb=%h, want 1 %h %b %h %h",
                 n, memory_valid, memory_addr, memory_instr, memory_wdata, memory_wstrb,
                 exp_addr, exp_instr, exp_wdata, exp_wstrb);
      end
      tests_run++;
      if (fp_memory_valid !== 1'b1 || fp_memory_addr !== 32'h0000_1000) begin
        tests_failed++;
        $display("FAIL fp_grant%0d: valid=%b addr=%h, want 1 00001000", n, fp_memory_valid, fp_memory_addr);
      end
      next_cycle();
      @(negedge clk);
      got_win  = ((n % 2) == 0) ? req_out[0] : req_out[1];
      got_lose = ((n % 2) == 0) ? req_out[1] : req_out[0];
      tests_run++;
      if (got_win !== {1'b1, 1'b0, 32'h1111_2222} || got_lose !== '0 ||
          memory_addr !== exp_addr || memory_wdata !== exp_wdata) begin
        tests_failed++;
        $display("FAIL rr_resp%0d: win=%h lose=%h addr=%h wdata=%h, want win=%h lose=0 addr=%h",
                 n, got_win, got_lose, memory_addr, memory_wdata, {1'b1, 1'b0, 32'h1111_2222}, exp_addr);
      end
      tests_run++;
      if (fp_req_out[0].mem_ready !== 1'b1 || fp_req_out[1] !== '0) begin
        tests_failed++;
        $display("FAIL fp_resp%0d: out0=%h out1=%h, want ready on port 0 only", n, fp_req_out[0], fp_req_out[1]);
      end
      next_cycle();
    end
    req_in[0]    = '0;
    req_in[1]    = '0;
    memory_ready = 1'b0;
    memory_rdata = '0;
    next_cycle();
  endtask

  task automatic test_pmp_error;
    req_in[1] = mk_req(1'b1, 1'b0, 32'h8000_0000, 32'h0, 4'h0);
    pmp_out   = '{mem_error: 1'b1};
    @(negedge clk);
    tests_run++;
    if (memory_valid !== 1'b0 || pmp_in.mem_addr !== 32'h8000_0000 || pmp_in.mem_valid !== 1'b1) begin
      tests_failed++;
      $display("FAIL pmp_grant: mem_valid=%b pmp_addr=%h pmp_valid=%b, want 0 80000000 1",
               memory_valid, pmp_in.mem_addr, pmp_in.mem_valid);
    end
    next_cycle();
    req_in[1] = '0;
    pmp_out   = '0;
    @(negedge clk);
    tests_run++;
    if (req_out[1] !== {1'b1, 1'b1, 32'h0} || req_out[0] !== '0) begin
      tests_failed++;
      $display("FAIL pmp_err_resp: out1=%h out0=%h, want out1=%h out0=0", req_out[1], req_out[0], {1'b1, 1'b1, 32'h0});
    end
    tests_run++;
    if (memory_valid !== 1'b0 || memory_addr !== 32'h0 || memory_instr !== 1'b0) begin
      tests_failed++;
      $display("FAIL pmp_err_mem: valid=%b addr=%h instr=%b, want 0", memory_valid, memory_addr, memory_instr);
    end
    next_cycle();
    @(negedge clk);
    tests_run++;
    if (req_out[1] !== '0 || memory_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL pmp_after: out1=%h valid=%b, want 0", req_out[1], memory_valid);
    end
    next_cycle();
  endtask

  // Load with three-cycle memory latency; requester drops valid after grant.
  task automatic test_load_latency;
    req_in[0] = mk_req(1'b1, 1'b0, 32'h0000_0100, 32'h0, 4'h0);
    @(negedge clk);
    tests_run++;
    if (memory_valid !== 1'b1 || memory_addr !== 32'h0000_0100) begin
      tests_failed++;
      $display("FAIL load_grant: valid=%b addr=%h, want 1 00000100", memory_valid, memory_addr);
    end
    next_cycle();
    req_in[0] = '0;
    for (int c = 1; c < 3; c++) begin
      @(negedge clk);
      tests_run++;
      if (memory_valid !== 1'b1 || memory_addr !== 32'h0000_0100 || req_out[0] !== '0) begin
        tests_failed++;
        $display("FAIL load_wait%0d: valid=%b addr=%h out0=%h, want 1 00000100 0", c, memory_valid, memory_addr, req_out[0]);
      end
      next_cycle();
    end
    memory_ready = 1'b1;
    memory_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    tests_run++;
    if (req_out[0] !== {1'b1, 1'b0, 32'hDEAD_BEEF} || memory_addr !== 32'h0000_0100 || req_out[1] !== '0) begin
      tests_failed++;
      $display("FAIL load_done: out0=%h addr=%h out1=%h, want %h 00000100 0",
               req_out[0], memory_addr, req_out[1], {1'b1, 1'b0, 32'hDEAD_BEEF});
    end
    next_cycle();
    memory_ready = 1'b0;
    memory_rdata = '0;
    @(negedge clk);
    tests_run++;
    if (req_out[0] !== '0 || memory_valid !== 1'b0 || memory_addr !== 32'h0 || memory_wstrb !== 4'h0) begin
      tests_failed++;
      $display("FAIL load_idle: out0=%h valid=%b addr=%h wstrb=%h, want 0", req_out[0], memory_valid, memory_addr, memory_wstrb);
    end
    next_cycle();
  endtask

  task automatic test_timeout;
    req_in[0]    = mk_req(1'b1, 1'b0, 32'h0000_0200, 32'h0, 4'h0);
    memory_ready = 1'b0;
    @(negedge clk);
    next_cycle();
    req_in[0] = '0;
    for (int c = 1; c <= 16; c++) begin
      @(negedge clk);
      if (c == 16) begin
        tests_run++;
        if (memory_valid !== 1'b1 || req_out[0] !== '0) begin
          tests_failed++;
          $display("FAIL tmo_busy16: valid=%b out0=%h, want 1 0", memory_valid, req_out[0]);
        end
      end
      next_cycle();
    end
    @(negedge clk);
`ifdef ARBITER_TIMEOUT_EN
    tests_run++;
    if (memory_valid !== 1'b0 || memory_addr !== 32'h0 || req_out[0] !== {1'b1, 1'b1, 32'h0}) begin
      tests_failed++;
      $display("FAIL tmo_abort: valid=%b addr=%h out0=%h, want 0 0 %h", memory_valid, memory_addr, req_out[0], {1'b1, 1'b1, 32'h0});
    end
    next_cycle();
    // memory_ready on the last allowed cycle wins over the timeout.
    req_in[0] = mk_req(1'b1, 1'b0, 32'h0000_0300, 32'h0, 4'h0);
    @(negedge clk);
    next_cycle();
    req_in[0] = '0;
    for (int c = 1; c < 16; c++) begin
      next_cycle();
    end
    memory_ready = 1'b1;
    memory_rdata = 32'hCAFE_0001;
    @(negedge clk);
    tests_run++;
    if (req_out[0] !== {1'b1, 1'b0, 32'hCAFE_0001}) begin
      tests_failed++;
      $display("FAIL tmo_edge_ready: out0=%h, want %h", req_out[0], {1'b1, 1'b0, 32'hCAFE_0001});
    end
    next_cycle();
    memory_ready = 1'b0;
    memory_rdata = '0;
    @(negedge clk);
    tests_run++;
    if (req_out[0] !== '0 || memory_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL tmo_edge_after: out0=%h valid=%b, want 0", req_out[0], memory_valid);
    end
    next_cycle();
`else
    tests_run++;
    if (memory_valid !== 1'b1 || memory_addr !== 32'h0000_0200 || req_out[0] !== '0) begin
      tests_failed++;
      $display("FAIL notmo_still_busy: valid=%b addr=%h out0=%h, want 1 00000200 0", memory_valid, memory_addr, req_out[0]);
    end
    repeat (20) next_cycle();
    memory_ready = 1'b1;
    memory_rdata = 32'h1234_5678;
    @(negedge clk);
    tests_run++;
    if (req_out[0] !== {1'b1, 1'b0, 32'h1234_5678}) begin
      tests_failed++;
      $display("FAIL notmo_done: out0=%h, want %h", req_out[0], {1'b1, 1'b0, 32'h1234_5678});
    end
    next_cycle();
    memory_ready = 1'b0;
    memory_rdata = '0;
    next_cycle();
`endif
  endtask

  task automatic test_reset_mid_access;
    req_in[0]    = mk_req(1'b1, 1'b0, 32'h0000_1000, 32'h0, 4'h0);
    req_in[1]    = mk_req(1'b1, 1'b1, 32'h0000_2000, 32'h0, 4'h0);
    memory_ready = 1'b0;
    @(negedge clk);
    tests_run++;
    if (memory_valid !== 1'b1) begin
      tests_failed++;
      $display("FAIL rstmid_grant: valid=%b, want 1", memory_valid);
    end
    next_cycle();
    rst = 1'b0;
    next_cycle();
    @(negedge clk);
    tests_run++;
    if (memory_valid !== 1'b0 || memory_addr !== 32'h0 || memory_instr !== 1'b0 || pmp_in !== '0 ||
        req_out[0] !== '0 || req_out[1] !== '0) begin
      tests_failed++;
      $display("FAIL rstmid_quiet: valid=%b addr=%h instr=%b pmp=%h out0=%h out1=%h, want 0",
               memory_valid, memory_addr, memory_instr, pmp_in, req_out[0], req_out[1]);
    end
    next_cycle();
    rst          = 1'b1;
    memory_ready = 1'b1;
    memory_rdata = 32'h0BAD_F00D;
    @(negedge clk);
    tests_run++;
    if (memory_valid !== 1'b1 || memory_addr !== 32'h0000_1000) begin
      tests_failed++;
      $display("FAIL rstmid_first: valid=%b addr=%h, want 1 00001000", memory_valid, memory_addr);
    end
    next_cycle();
    @(negedge clk);
    tests_run++;
    if (req_out[0] !== {1'b1, 1'b0, 32'h0BAD_F00D} || req_out[1] !== '0) begin
      tests_failed++;
      $display("FAIL rstmid_resp: out0=%h out1=%h, want %h 0", req_out[0], req_out[1], {1'b1, 1'b0, 32'h0BAD_F00D});
    end
    next_cycle();
    @(negedge clk);
    tests_run++;
    if (memory_valid !== 1'b1 || memory_addr !== 32'h0000_2000) begin
      tests_failed++;
      $display("FAIL rstmid_second: valid=%b addr=%h, want 1 00002000", memory_valid, memory_addr);
    end
    next_cycle();
    req_in[0] = '0;
    req_in[1] = '0;
    next_cycle();
    memory_ready = 1'b0;
    next_cycle();
  endtask

  initial begin
    test_reset();
    test_arbitration();
    test_pmp_error();
    test_load_latency();
    test_timeout();
    test_reset_mid_access();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
